// File: rtl/rggen_register_bus_arbiter.sv
// Round-robin arbiter sharing one rggen register bus between HOSTS masters.
// One transaction at a time: IDLE (arbitrate) -> BUSY (wait ready) -> RESP (ready pulse).
module rggen_register_bus_arbiter #(
  parameter int HOSTS         = 2,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int INDEX_WIDTH   = (HOSTS > 1) ? $clog2(HOSTS) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [HOSTS-1:0]               i_host_valid,
  input  logic [2*HOSTS-1:0]             i_host_access,
  input  logic [ADDRESS_WIDTH*HOSTS-1:0] i_host_address,
  input  logic [BUS_WIDTH*HOSTS-1:0]     i_host_write_data,
  input  logic [BUS_WIDTH*HOSTS-1:0]     i_host_strobe,
  output logic [HOSTS-1:0]               o_host_ready,
  output logic [1:0]                     o_host_status,
  output logic [BUS_WIDTH-1:0]           o_host_read_data,
  output logic                           o_register_valid,
  output logic [1:0]                     o_register_access,
  output logic [ADDRESS_WIDTH-1:0]       o_register_address,
  output logic [BUS_WIDTH-1:0]           o_register_write_data,
  output logic [BUS_WIDTH-1:0]           o_register_strobe,
  input  logic                           i_register_ready,
  input  logic [1:0]                     i_register_status,
  input  logic [BUS_WIDTH-1:0]           i_register_read_data,
  output logic [INDEX_WIDTH-1:0]         o_grant_index
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                   state_q;
  logic [INDEX_WIDTH-1:0]   ptr_q;
  logic [INDEX_WIDTH-1:0]   grant_q;
  logic [HOSTS-1:0]         host_ready_q;
  logic [1:0]               host_status_q;
  logic [BUS_WIDTH-1:0]     host_read_data_q;
  logic                     reg_valid_q;
  logic [1:0]               reg_access_q;
  logic [ADDRESS_WIDTH-1:0] reg_address_q;
  logic [BUS_WIDTH-1:0]     reg_write_data_q;
  logic [BUS_WIDTH-1:0]     reg_strobe_q;

  logic                     win_found;
  logic [INDEX_WIDTH-1:0]   win_idx;
  logic [INDEX_WIDTH-1:0]   cand;

  // First valid host at or above the pointer, wrapping modulo HOSTS.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < HOSTS; k++) begin
      cand = INDEX_WIDTH'((int'(ptr_q) + k) % HOSTS);
      if (!win_found && i_host_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q          <= StIdle;
      ptr_q            <= '0;
      grant_q          <= '0;
      host_ready_q     <= '0;
      host_status_q    <= '0;
      host_read_data_q <= '0;
      reg_valid_q      <= 1'b0;
      reg_access_q     <= '0;
      reg_address_q    <= '0;
      reg_write_data_q <= '0;
      reg_strobe_q     <= '0;
    end else begin
      host_ready_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            grant_q          <= win_idx;
            reg_valid_q      <= 1'b1;
            reg_access_q     <= i_host_access[2*int'(win_idx)+:2];
            reg_address_q    <= i_host_address[ADDRESS_WIDTH*int'(win_idx)+:ADDRESS_WIDTH];
            reg_write_data_q <= i_host_write_data[BUS_WIDTH*int'(win_idx)+:BUS_WIDTH];
            reg_strobe_q     <= i_host_strobe[BUS_WIDTH*int'(win_idx)+:BUS_WIDTH];
            state_q          <= StBusy;
          end
        end
        StBusy: begin
          if (i_register_ready) begin
            reg_valid_q      <= 1'b0;
            host_status_q    <= i_register_status;
            host_read_data_q <= i_register_read_data;
            host_ready_q     <= HOSTS'(1) << grant_q;
            ptr_q            <= INDEX_WIDTH'((int'(grant_q) + 1) % HOSTS);
            state_q          <= StResp;
          end
        end
        // Granted host still holds valid this cycle, so skip arbitration.
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_host_ready          = host_ready_q;
  assign o_host_status         = host_status_q;
  assign o_host_read_data      = host_read_data_q;
  assign o_register_valid      = reg_valid_q;
  assign o_register_access     = reg_access_q;
  assign o_register_address    = reg_address_q;
  assign o_register_write_data = reg_write_data_q;
  assign o_register_strobe     = reg_strobe_q;
  assign o_grant_index         = grant_q;

endmodule

// File: tb/tb_rggen_register_bus_arbiter.sv
// Bench for rggen_register_bus_arbiter: table-driven single-host transactions with a
// request/response scoreboard, plus hand sequences for round-robin, RESP and reset corners.
module tb_rggen_register_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // HOSTS=2 instance
  logic [1:0]  valid2 = '0;
  logic [3:0]  acc2 = '0;
  logic [15:0] addr2 = '0;
  logic [63:0] wd2 = '0, stb2 = '0;
  logic [1:0]  hrdy2, hst2;
  logic [31:0] hrd2;
  logic        rv2;
  logic [1:0]  ra2;
  logic [7:0]  raddr2;
  logic [31:0] rwd2, rstb2;
  logic        rrdy2 = 1'b0;
  logic [1:0]  rst2 = '0;
  logic [31:0] rrd2 = '0;
  logic        gidx2;

  rggen_register_bus_arbiter #(.HOSTS(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_host_valid(valid2), .i_host_access(acc2), .i_host_address(addr2),
    .i_host_write_data(wd2), .i_host_strobe(stb2),
    .o_host_ready(hrdy2), .o_host_status(hst2), .o_host_read_data(hrd2),
    .o_register_valid(rv2), .o_register_access(ra2), .o_register_address(raddr2),
    .o_register_write_data(rwd2), .o_register_strobe(rstb2),
    .i_register_ready(rrdy2), .i_register_status(rst2), .i_register_read_data(rrd2),
    .o_grant_index(gidx2)
  );

  // HOSTS=4 instance, register side always ready
  logic [3:0]   valid4 = '0;
  logic [7:0]   acc4 = '0;
  logic [31:0]  addr4 = {8'h43, 8'h42, 8'h41, 8'h40};
  logic [127:0] wd4 = '0, stb4 = '0;
  logic [3:0]   hrdy4;
  logic [1:0]   hst4;
  logic [31:0]  hrd4;
  logic         rv4;
  logic [1:0]   ra4;
  logic [7:0]   raddr4;
  logic [31:0]  rwd4, rstb4;
  logic [1:0]   gidx4;

  rggen_register_bus_arbiter #(.HOSTS(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_host_valid(valid4), .i_host_access(acc4), .i_host_address(addr4),
    .i_host_write_data(wd4), .i_host_strobe(stb4),
    .o_host_ready(hrdy4), .o_host_status(hst4), .o_host_read_data(hrd4),
    .o_register_valid(rv4), .o_register_access(ra4), .o_register_address(raddr4),
    .o_register_write_data(rwd4), .o_register_strobe(rstb4),
    .i_register_ready(1'b1), .i_register_status(2'b00), .i_register_read_data(32'h0),
    .o_grant_index(gidx4)
  );

  typedef struct {
    int          host;
    logic [1:0]  acc;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] strobe;
    int          delay;   // cycles o_register_valid is high before completion
    logic [1:0]  st;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    int          idx;
    logic [1:0]  acc;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] strobe;
  } req_t;

  typedef struct {
    logic [1:0]  mask;
    logic [1:0]  st;
    logic [31:0] rdata;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  vec_t vecs[5];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    req_t r;
    rsp_t p;
    int   other;
    bit   seen;
    other = 1 - v.host;
    valid2                    = '0;
    valid2[v.host]            = 1'b1;
    acc2[2*v.host+:2]         = v.acc;
    addr2[8*v.host+:8]        = v.addr;
    wd2[32*v.host+:32]        = v.wdata;
    stb2[32*v.host+:32]       = v.strobe;
    acc2[2*other+:2]          = ~v.acc;
    addr2[8*other+:8]         = ~v.addr;
    wd2[32*other+:32]         = ~v.wdata;
    stb2[32*other+:32]        = ~v.strobe;
    r = '{idx: v.host, acc: v.acc, addr: v.addr, wdata: v.wdata, strobe: v.strobe};
    req_q.push_back(r);
    @(negedge clk);
    chk("arb_latency", rv2, 1);
    seen = rv2;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = rv2;
    end
    if (!seen) begin
      chk("req_timeout", 0, 1);
      valid2 = '0;
      void'(req_q.pop_front());
      return;
    end
    r = req_q.pop_front();
    chk("req_grant", gidx2, r.idx);
    chk("req_fields", {ra2, raddr2, rwd2, rstb2}, {r.acc, r.addr, r.wdata, r.strobe});
    for (int i = 1; i < v.delay; i++) begin
      @(negedge clk);
      chk("stall_hold", {rv2, ra2, raddr2, rwd2, rstb2, hrdy2},
          {1'b1, r.acc, r.addr, r.wdata, r.strobe, 2'b00});
    end
    rrdy2 = 1'b1;
    rst2  = v.st;
    rrd2  = v.rdata;
    p = '{mask: 2'(1 << v.host), st: v.st, rdata: v.rdata};
    rsp_q.push_back(p);
    @(negedge clk);
    rrdy2  = 1'b0;
    rst2   = ~v.st;
    rrd2   = ~v.rdata;
    valid2 = '0;
    p = rsp_q.pop_front();
    chk("resp_ready", hrdy2, p.mask);
    chk("resp_status", hst2, p.st);
    chk("resp_rdata", hrd2, p.rdata);
    chk("resp_valid_low", rv2, 0);
    @(negedge clk);
    chk("ready_one_cycle", hrdy2, 2'b00);
    chk("resp_hold", {hst2, hrd2, gidx2}, {p.st, p.rdata, 1'(v.host)});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{0, 2'b00, 8'h10, 32'h0,         32'h0,         2, 2'b00, 32'hDEADBEEF};
    vecs[1] = '{1, 2'b11, 8'h24, 32'h0000_00A5, 32'h0000_00FF, 6, 2'b10, 32'h0};
    vecs[2] = '{0, 2'b01, 8'hFF, 32'h1234_5678, 32'hFFFF_0000, 1, 2'b01, 32'hCAFEF00D};
    vecs[3] = '{1, 2'b00, 8'h00, 32'h0,         32'h0,         3, 2'b11, 32'h5A5A5A5A};
    vecs[4] = '{0, 2'b10, 8'h3C, 32'h0,         32'h0,         1, 2'b00, 32'h0BADC0DE};

    // Reset values
    #1;
    chk("rst_outputs2", {hrdy2, hst2, hrd2, rv2, ra2, raddr2, rwd2, rstb2, gidx2}, '0);
    chk("rst_outputs4", {hrdy4, rv4, gidx4}, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_req", rv2, 0);

    for (int i = 0; i < 4; i++) run_txn(vecs[i]);

    // Both hosts continuously valid, ready immediate: 0,1,0,1 every 3 cycles
    acc2 = '0; addr2 = {8'h71, 8'h70}; wd2 = '0; stb2 = '0;
    valid2 = 2'b11;
    rrdy2  = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("rr_grant", {rv2, gidx2, raddr2}, {1'b1, 1'(t % 2), 8'h70 + 8'(t % 2)});
      @(negedge clk);
      chk("rr_ready", {hrdy2, rv2}, {2'(1 << (t % 2)), 1'b0});
      @(negedge clk);
      chk("rr_idle", {hrdy2, rv2}, 3'b000);
    end
    valid2 = '0;

    // Host0 raised while host1 is in RESP: no grant until the following IDLE
    valid2 = 2'b10;
    @(negedge clk);
    chk("resp_h1_grant", {rv2, gidx2}, 2'b11);
    @(negedge clk);
    chk("resp_h1_ready", hrdy2, 2'b10);
    valid2 = 2'b01;
    @(negedge clk);
    chk("resp_no_arb", rv2, 0);
    @(negedge clk);
    chk("resp_h0_grant", {rv2, gidx2}, 2'b10);
    @(negedge clk);
    chk("resp_h0_ready", hrdy2, 2'b01);
    valid2 = '0;
    rrdy2  = 1'b0;
    @(negedge clk);

    // HOSTS=4: move pointer to 2 via host1, then hosts 1 and 3 -> 3, 1, pointer back at 2
    valid4 = 4'b0010;
    @(negedge clk);
    chk("h4_first", {rv4, gidx4, raddr4}, {1'b1, 2'd1, 8'h41});
    @(negedge clk);
    chk("h4_first_ready", hrdy4, 4'b0010);
    valid4 = 4'b1010;
    @(negedge clk);
    @(negedge clk);
    chk("h4_grant3", {rv4, gidx4, raddr4}, {1'b1, 2'd3, 8'h43});
    @(negedge clk);
    chk("h4_ready3", hrdy4, 4'b1000);
    valid4 = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    chk("h4_grant1", {rv4, gidx4, raddr4}, {1'b1, 2'd1, 8'h41});
    @(negedge clk);
    chk("h4_ready1", hrdy4, 4'b0010);
    valid4 = 4'b1001;
    @(negedge clk);
    @(negedge clk);
    chk("h4_ptr_at_2", gidx4, 2'd3);
    valid4 = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset while BUSY: pointer is 1 after host0, both valid -> host1 granted, then reset
    run_txn(vecs[4]);
    valid2 = 2'b11;
    @(negedge clk);
    chk("pre_rst_grant", {rv2, gidx2}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {rv2, gidx2, hrdy2}, '0);
    @(negedge clk);
    chk("rst_no_ready", hrdy2, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_host0", {rv2, gidx2, hrdy2}, {1'b1, 1'b0, 2'b00});
    rrdy2 = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", hrdy2, 2'b01);
    valid2 = '0;
    rrdy2  = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rggen_register_bus_arbiter.md
Name: rggen_register_bus_arbiter

Overview:
- Shares one rggen register bus between HOSTS independent bus masters, e.g. a CPU bridge and a debug port.
- Its register-side outputs drive the common register bus that fans out to all rggen register instances: valid, access, address, write data and strobe in; ready, status and read data back.
- Arbitration is round-robin, one transaction at a time.
- Each grant is held until the register side returns ready.

Parameters:
HOSTS, 2, number of requesting masters (1..16)
ADDRESS_WIDTH, 8, register address width
BUS_WIDTH, 32, data and strobe width
INDEX_WIDTH, (HOSTS > 1) ? $clog2(HOSTS) : 1, width of the grant index

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_host_valid  input  HOSTS  request valid per host
i_host_access  input  2*HOSTS  access type per host; host h uses bits [2h+1:2h]
i_host_address  input  ADDRESS_WIDTH*HOSTS  address per host, packed
i_host_write_data  input  BUS_WIDTH*HOSTS  write data per host, packed
i_host_strobe  input  BUS_WIDTH*HOSTS  bit strobe per host, packed
o_host_ready  output  HOSTS  one-cycle completion pulse per host
o_host_status  output  2  response status, shared by all hosts
o_host_read_data  output  BUS_WIDTH  response read data, shared by all hosts
o_register_valid  output  1  register bus request valid
o_register_access  output  2  register bus access type
o_register_address  output  ADDRESS_WIDTH  register bus address
o_register_write_data  output  BUS_WIDTH  register bus write data
o_register_strobe  output  BUS_WIDTH  register bus strobe
i_register_ready  input  1  register bus ready
i_register_status  input  2  register bus status
i_register_read_data  input  BUS_WIDTH  register bus read data
o_grant_index  output  INDEX_WIDTH  index of the host currently or last granted

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst_n is asynchronous and active-low. All state and all outputs are flopped.
- Reset values:
  - all outputs 0;
  - state IDLE;
  - round-robin pointer = 0, so host 0 has highest priority.
- State machine IDLE -> BUSY -> RESP -> IDLE.
- IDLE, arbitration:
  - If any i_host_valid is high, choose the first set bit searching from the pointer upward, wrapping modulo HOSTS.
  - Latch that host's access, address, write data and strobe into the o_register_* flops.
  - Set o_register_valid=1 and o_grant_index=winner, then go to BUSY.
  - Arbitration latency is 1 cycle: if the request is seen at cycle T, o_register_valid is high at T+1.
  - If no host is valid, stay in IDLE.
- BUSY:
  - o_register_valid and all o_register_* fields are held stable until i_register_ready is sampled high.
  - On that edge:
    - clear o_register_valid;
    - capture i_register_status into o_host_status and i_register_read_data into o_host_read_data;
    - set o_host_ready[grant]=1;
    - set pointer = (grant+1) mod HOSTS;
    - go to RESP.
  - i_register_ready high in the same cycle o_register_valid rises completes the transaction (minimum one BUSY cycle).
  - BUSY has no timeout; a register bus that never returns ready hangs the arbiter.
- RESP:
  - o_host_ready is high for exactly this one cycle.
  - No arbitration happens here, because the granted host's valid is still high this cycle; return to IDLE.
  - o_host_status and o_host_read_data hold their captured values until the next completion and are not cleared.
- Throughput: at most one transaction per 3 cycles (IDLE, BUSY, RESP) when ready returns immediately.
- Host protocol:
  - A host keeps valid and its fields stable from assertion until it sees its o_host_ready pulse.
  - Changes made while the host is not granted are simply re-evaluated at the next IDLE.
  - A host dropping valid while granted is a protocol violation. The arbiter still completes the latched transaction and pulses ready.
- o_grant_index holds its value after completion and is not cleared in IDLE.
- Simultaneous requests: the pointer decides. With all hosts continuously valid, the grant order is 0,1,...,HOSTS-1,0,...
- Pointer wrap: from grant HOSTS-1 the pointer returns to 0.
- HOSTS=1: the pointer is constant 0 and the block degenerates to a registered pass-through with the same 3-state timing.
- Reset mid-transaction: everything returns to reset values immediately (asynchronously). The aborted transaction gets no ready pulse.
- i_register_status and i_register_read_data are ignored outside BUSY.

Test Plan:
- HOSTS=2, host0 read at address 0x10, i_register_ready after 2 BUSY cycles with read data 0xDEADBEEF and status 2'b00 -> o_register_valid high 2 cycles, o_register_address=0x10, then o_host_ready=2'b01 for one cycle with o_host_read_data=0xDEADBEEF.
- Host0 and host1 both valid continuously, ready returns immediately -> grants alternate 0,1,0,1 and each transaction spans 3 cycles.
- HOSTS=4, only hosts 1 and 3 valid, pointer=2 -> host3 granted first, then host1, then the pointer wraps to 2.
- Write from host1: access=2'b11, write data 0x0000_00A5, strobe 0x0000_00FF -> register bus shows the identical fields, stable through a 5-cycle ready stall; status 2'b10 is returned to host1 only.
- i_rst_n pulled low while in BUSY -> o_register_valid drops immediately, no o_host_ready pulse, and the next request after reset is granted to host 0 first.
- Host0 valid while host1's transaction is in RESP -> host0 is not granted until the following IDLE cycle.
